// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    // Bubble encoding; matches the value IF/ID loads on a flush.
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, drops stale responses after redirect.
// Latency: accept at T, response at T+k, if_valid from T+k+1; consumption clears if_valid next cycle.
// Backpressure: id_stall holds the presented instruction; imem_ready stalls the request in FETCH.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc_p4,
    output logic [31:0] if_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_p4_q, pc_p4_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_p4_d  = pc_p4_q;
        valid_d  = valid_q;
        pc_plus4 = pc_q + 32'd4;

        if (redirect) begin
            // Any request already accepted for the old PC must have its response dropped.
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            pc_p4_d = 32'h0;
            case (state_q)
                FETCH:   state_d = imem_ready  ? DROP  : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DROP;
                HOLD:    state_d = FETCH;
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        pc_p4_d = pc_plus4;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        pc_d    = pc_plus4;
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                        pc_p4_d = 32'h0;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc_p4_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc_p4_q <= pc_p4_d;
            valid_q <= valid_d;
        end
    end

    // State resets to FETCH, so the request is gated to stay low while reset is held.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_inst   = inst_q;
    assign if_pc_p4  = pc_p4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with programmable latency plus an expected-fetch scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc_p4;
    logic [31:0] if_inst;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          lat      = 2;
    logic [31:0] acc_addr = 32'h0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_stall   (id_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc_p4   (if_pc_p4),
        .if_inst    (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 60) begin
            cyc();
            n++;
        end
        check_eq(tag, {31'b0, if_valid}, 32'd1);
    endtask

    // Waits for the next request, checking that nothing becomes valid in the meantime.
    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 60) begin
            check_eq({tag, "_no_valid"}, {31'b0, if_valid}, 32'd0);
            cyc();
            n++;
        end
        check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    endtask

    // Memory model: one outstanding request, response lat cycles after acceptance.
    initial begin
        bit          pend = 0;
        int          cnt  = 0;
        logic [31:0] paddr = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #3;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend) begin
                    if (cnt == 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(paddr);
                        pend        = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req && imem_ready) begin
                    pend     = 1;
                    cnt      = lat;
                    paddr    = imem_addr;
                    acc_addr = imem_addr;
                end
            end
        end
    end

    // Scoreboard: an instruction leaves IF when consumed or flushed by redirect.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && if_valid && (!id_stall || redirect)) begin
                check_eq("sb_depth", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_inst", if_inst, mem_word(e));
                    check_eq("sb_pc_p4", if_pc_p4, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_p4;
        rst_n       = 1'b0;
        id_stall    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        lat         = 2;
        #2;
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_inst", if_inst, 32'h0);
        check_eq("rst_pc_p4", if_pc_p4, 32'h0);

        // First fetch after reset, then stall in HOLD.
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check_eq("first_req", {31'b0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        wait_valid("first_valid");
        check_eq("first_inst", if_inst, 32'h00A0_0093);
        check_eq("first_pc_p4", if_pc_p4, 32'h4);
        held_inst = if_inst;
        held_p4   = if_pc_p4;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("stall_inst", if_inst, held_inst);
            check_eq("stall_pc_p4", if_pc_p4, held_p4);
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
        end
        cyc();
        id_stall = 1'b0;
        cyc();
        id_stall = 1'b1;
        check_eq("next_req", {31'b0, imem_req}, 32'd1);
        check_eq("next_addr", imem_addr, 32'h4);
        check_eq("next_valid", {31'b0, if_valid}, 32'd0);
        exp_q.push_back(32'h4);
        wait_valid("pc4_valid");

        // Redirect while a response is outstanding (WAIT).
        cyc();
        id_stall = 1'b0;
        cyc();
        id_stall = 1'b1;
        lat      = 5;
        cyc();
        check_eq("wait_req", {31'b0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        lat      = 1;
        check_eq("drop_req", {31'b0, imem_req}, 32'd0);
        check_eq("drop_addr", imem_addr, 32'h0000_0100);
        wait_req("wait_redir");
        check_eq("wait_redir_addr", imem_addr, 32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        wait_valid("redir_valid");

        // Redirect in the same cycle the FETCH request is accepted.
        cyc();
        id_stall = 1'b0;
        cyc();
        id_stall    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        lat         = 3;
        check_eq("acc_redir_req", {31'b0, imem_req}, 32'd1);
        cyc();
        redirect = 1'b0;
        check_eq("acc_redir_old", acc_addr, 32'h0000_0104);
        check_eq("acc_redir_req0", {31'b0, imem_req}, 32'd0);
        check_eq("acc_redir_addr", imem_addr, 32'h0000_0200);
        lat = 2;
        wait_req("acc_drop");
        check_eq("acc_drop_addr", imem_addr, 32'h0000_0200);
        exp_q.push_back(32'h0000_0200);
        wait_valid("target_valid");

        // Redirect together with id_stall in HOLD flushes the held instruction.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        cyc();
        redirect = 1'b0;
        check_eq("hold_redir_valid", {31'b0, if_valid}, 32'd0);
        check_eq("hold_redir_inst", if_inst, 32'h0);
        check_eq("hold_redir_pc_p4", if_pc_p4, 32'h0);
        check_eq("hold_redir_req", {31'b0, imem_req}, 32'd1);
        check_eq("hold_redir_addr", imem_addr, 32'h0000_0300);
        exp_q.push_back(32'h0000_0300);
        wait_valid("hold_redir_fetch");

        // PC wrap at the top of the address space.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        wait_valid("wrap_valid");
        check_eq("wrap_pc_p4", if_pc_p4, 32'h0);
        cyc();
        id_stall = 1'b0;
        cyc();
        id_stall = 1'b1;
        check_eq("wrap_next_req", {31'b0, imem_req}, 32'd1);
        check_eq("wrap_next_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        wait_valid("wrap_fetch0");

        // Asynchronous reset while waiting for a response.
        cyc();
        id_stall = 1'b0;
        lat      = 4;
        cyc();
        id_stall = 1'b1;
        cyc();
        check_eq("pre_rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("pre_rst_addr", imem_addr, 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", {31'b0, imem_req}, 32'd0);
        check_eq("arst_addr", imem_addr, 32'h0);
        check_eq("arst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("arst_inst", if_inst, 32'h0);
        check_eq("arst_pc_p4", if_pc_p4, 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        lat   = 2;
        #1;
        check_eq("rerun_req", {31'b0, imem_req}, 32'd1);
        check_eq("rerun_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        wait_valid("rerun_valid");
        check_eq("rerun_inst", if_inst, 32'h00A0_0093);
        cyc();
        id_stall = 1'b0;
        cyc();
        id_stall = 1'b1;
        cyc();
        check_eq("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
